// File: rtl/fifo_wr_arbiter.sv
// Two-requester round-robin write arbiter for the capture FIFO.
// One-entry holding register per requester, source-tagged output word, saturating drop counters.
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH     = 8,
  parameter int DROP_CNT_WIDTH = 8,
  parameter int LOCK_LOW_PRIO  = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req0_dv,
  input  logic [DATA_WIDTH-1:0]     req0_DATA,
  output logic                      req0_rdy,
  input  logic                      req1_dv,
  input  logic [DATA_WIDTH-1:0]     req1_DATA,
  output logic                      req1_rdy,
  output logic                      fifo_wr_dv,
  output logic [DATA_WIDTH:0]       fifo_wr_DATA,
  input  logic                      fifo_wr_full,
  input  logic                      fifo_wr_almost_full,
  input  logic                      clr_drops,
  output logic [DROP_CNT_WIDTH-1:0] drop0_cnt,
  output logic [DROP_CNT_WIDTH-1:0] drop1_cnt
);

  localparam logic LOCK = (LOCK_LOW_PRIO != 0);

  logic [DATA_WIDTH-1:0] hold0, hold1;
  logic                  h0_v, h1_v;
  logic                  last_grant;
  logic                  e0, e1, blocked;
  logic                  grant0, grant1;

  assign e0      = h0_v;
  assign e1      = h1_v & ~(LOCK & fifo_wr_almost_full);
  assign blocked = rst | fifo_wr_full;

  // On a tie the requester that did not win last time gets the port.
  assign grant0 = ~blocked & e0 & (~e1 | last_grant);
  assign grant1 = ~blocked & e1 & (~e0 | ~last_grant);

  assign fifo_wr_dv   = grant0 | grant1;
  assign fifo_wr_DATA = grant1 ? {1'b1, hold1} : {1'b0, hold0};

  assign req0_rdy = ~rst & (~h0_v | grant0);
  assign req1_rdy = ~rst & (~h1_v | grant1);

  always_ff @(posedge clk) begin
    if (rst) begin
      hold0      <= '0;
      hold1      <= '0;
      h0_v       <= 1'b0;
      h1_v       <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      if (grant0 | grant1)
        last_grant <= grant1;

      if (req0_dv & req0_rdy) begin
        hold0 <= req0_DATA;
        h0_v  <= 1'b1;
      end else if (grant0) begin
        h0_v  <= 1'b0;
      end

      if (req1_dv & req1_rdy) begin
        hold1 <= req1_DATA;
        h1_v  <= 1'b1;
      end else if (grant1) begin
        h1_v  <= 1'b0;
      end
    end
  end

  // Clear wins over a same-cycle drop; counts stick at all-ones.
  always_ff @(posedge clk) begin
    if (rst || clr_drops) begin
      drop0_cnt <= '0;
      drop1_cnt <= '0;
    end else begin
      if (req0_dv & ~req0_rdy & ~(&drop0_cnt))
        drop0_cnt <= drop0_cnt + 1'b1;
      if (req1_dv & ~req1_rdy & ~(&drop1_cnt))
        drop1_cnt <= drop1_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed-vector bench for fifo_wr_arbiter.
module tb_fifo_wr_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_dv = 1'b0, req1_dv = 1'b0;
  logic [7:0] req0_DATA = '0, req1_DATA = '0;
  logic       req0_rdy, req1_rdy;
  logic       fifo_wr_dv;
  logic [8:0] fifo_wr_DATA;
  logic       fifo_wr_full = 1'b0, fifo_wr_almost_full = 1'b0;
  logic       clr_drops = 1'b0;
  logic [7:0] drop0_cnt, drop1_cnt;

  int n_vec = 0;
  int n_err = 0;

  fifo_wr_arbiter #(.DATA_WIDTH(8), .DROP_CNT_WIDTH(8), .LOCK_LOW_PRIO(1)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .req0_dv             (req0_dv),
    .req0_DATA           (req0_DATA),
    .req0_rdy            (req0_rdy),
    .req1_dv             (req1_dv),
    .req1_DATA           (req1_DATA),
    .req1_rdy            (req1_rdy),
    .fifo_wr_dv          (fifo_wr_dv),
    .fifo_wr_DATA        (fifo_wr_DATA),
    .fifo_wr_full        (fifo_wr_full),
    .fifo_wr_almost_full (fifo_wr_almost_full),
    .clr_drops           (clr_drops),
    .drop0_cnt           (drop0_cnt),
    .drop1_cnt           (drop1_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0_dv = 1'b0;
    req1_dv = 1'b0;
    fifo_wr_full = 1'b0;
    fifo_wr_almost_full = 1'b0;
    clr_drops = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int i0, i1, w;
    logic any_wr;
    logic [8:0] exp_w;

    // Reset with both requesters pushing
    rst = 1'b1;
    req0_dv = 1'b1; req1_dv = 1'b1;
    req0_DATA = 8'h5A; req1_DATA = 8'hA5;
    #1;
    for (int k = 0; k < 3; k++) begin
      check("rst_wr_dv", 32'(fifo_wr_dv), 32'd0);
      check("rst_rdy0", 32'(req0_rdy), 32'd0);
      check("rst_rdy1", 32'(req1_rdy), 32'd0);
      tick();
    end
    rst = 1'b0;
    req0_dv = 1'b0; req1_dv = 1'b0;
    #1;
    check("post_rst_drop0", 32'(drop0_cnt), 32'd0);
    check("post_rst_drop1", 32'(drop1_cnt), 32'd0);
    check("post_rst_rdy0", 32'(req0_rdy), 32'd1);
    check("post_rst_rdy1", 32'(req1_rdy), 32'd1);
    check("post_rst_wr_dv", 32'(fifo_wr_dv), 32'd0);

    // Single source streaming
    do_reset();
    req0_dv = 1'b1; req0_DATA = 8'h11;
    tick();
    req0_DATA = 8'h22; #1;
    check("s0_wr_dv", 32'(fifo_wr_dv), 32'd1);
    check("s0_data", 32'(fifo_wr_DATA), 32'h011);
    tick();
    req0_DATA = 8'h33; #1;
    check("s1_data", 32'(fifo_wr_DATA), 32'h022);
    tick();
    req0_dv = 1'b0; #1;
    check("s2_wr_dv", 32'(fifo_wr_dv), 32'd1);
    check("s2_data", 32'(fifo_wr_DATA), 32'h033);
    tick();
    check("s_idle_wr_dv", 32'(fifo_wr_dv), 32'd0);
    check("s_drop0", 32'(drop0_cnt), 32'd0);

    // Contention, requesters honour rdy
    do_reset();
    i0 = 0; i1 = 0;
    for (int k = 0; k < 9; k++) begin
      req0_DATA = 8'hA0 + 8'(i0);
      req1_DATA = 8'hB0 + 8'(i1);
      #1;
      req0_dv = req0_rdy;
      req1_dv = req1_rdy;
      if (k > 0) begin
        w = k - 1;
        exp_w = (w % 2 == 0) ? (9'h0A0 + 9'(w / 2)) : (9'h1B0 + 9'(w / 2));
        check("c_wr_dv", 32'(fifo_wr_dv), 32'd1);
        check("c_data", 32'(fifo_wr_DATA), 32'(exp_w));
      end
      if (req0_dv) i0++;
      if (req1_dv) i1++;
      tick();
    end
    req0_dv = 1'b0; req1_dv = 1'b0;
    #1;
    check("c_drop0", 32'(drop0_cnt), 32'd0);
    check("c_drop1", 32'(drop1_cnt), 32'd0);

    // Almost-full throttle of requester 1
    do_reset();
    req0_dv = 1'b1; req0_DATA = 8'h55;
    req1_dv = 1'b1; req1_DATA = 8'h66;
    tick();
    req0_dv = 1'b0; req1_dv = 1'b0;
    fifo_wr_almost_full = 1'b1; #1;
    check("af_wr_dv", 32'(fifo_wr_dv), 32'd1);
    check("af_data", 32'(fifo_wr_DATA), 32'h055);
    check("af_rdy1", 32'(req1_rdy), 32'd0);
    tick();
    check("af_blocked", 32'(fifo_wr_dv), 32'd0);
    req1_dv = 1'b1; req1_DATA = 8'h77;
    tick();
    req1_dv = 1'b0; #1;
    check("af_drop1", 32'(drop1_cnt), 32'd1);
    check("af_still_blocked", 32'(fifo_wr_dv), 32'd0);
    fifo_wr_almost_full = 1'b0; #1;
    check("af_rel_wr_dv", 32'(fifo_wr_dv), 32'd1);
    check("af_rel_data", 32'(fifo_wr_DATA), 32'h166);
    tick();
    check("af_done", 32'(fifo_wr_dv), 32'd0);

    // Full stall and drop-counter saturation
    do_reset();
    fifo_wr_full = 1'b1;
    req0_dv = 1'b1; req0_DATA = 8'h10;
    any_wr = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (fifo_wr_dv) any_wr = 1'b1;
      tick();
      req0_DATA = 8'h10 + 8'(k + 1);
    end
    check("full_no_wr", 32'(any_wr), 32'd0);
    check("full_sat", 32'(drop0_cnt), 32'd255);
    clr_drops = 1'b1;
    tick();
    clr_drops = 1'b0; req0_dv = 1'b0; #1;
    check("clr_over_drop", 32'(drop0_cnt), 32'd0);
    fifo_wr_full = 1'b0; #1;
    check("full_rel_wr_dv", 32'(fifo_wr_dv), 32'd1);
    check("full_rel_data", 32'(fifo_wr_DATA), 32'h010);

    // Grant plus refill
    do_reset();
    req0_dv = 1'b1; req0_DATA = 8'h21;
    tick();
    req0_DATA = 8'h42; #1;
    check("gr_rdy0", 32'(req0_rdy), 32'd1);
    check("gr_data0", 32'(fifo_wr_DATA), 32'h021);
    tick();
    req0_dv = 1'b0; #1;
    check("gr_wr_dv", 32'(fifo_wr_dv), 32'd1);
    check("gr_data1", 32'(fifo_wr_DATA), 32'h042);
    check("gr_drop0", 32'(drop0_cnt), 32'd0);
    tick();
    check("gr_idle", 32'(fifo_wr_dv), 32'd0);

    // Reset mid-operation discards held words
    req0_dv = 1'b1; req1_dv = 1'b1;
    tick();
    do_reset();
    #1;
    check("mid_rst_wr_dv", 32'(fifo_wr_dv), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Two-requester write arbiter for the sniffer's capture FIFO. It sits between the capture sources and the FIFO's write port. Requester 0 carries ULPI packet bytes; requester 1 carries low-priority status/event bytes. Each requester gets a one-entry holding register, and the block grants the single FIFO write port round-robin. Every written word is tagged with its source, requester 1 is throttled while the FIFO is almost full, and each requester has a saturating drop counter.

## Interface
Parameters:
- `DATA_WIDTH`, 8: payload width per requester; FIFO word is `DATA_WIDTH+1`.
- `DROP_CNT_WIDTH`, 8: width of each drop counter.
- `LOCK_LOW_PRIO`, 1: when 1, requester 1 is ineligible while `fifo_wr_almost_full` is high.

Ports:
- `clk`  in  1  reference clock; all state updates on posedge.
- `rst`  in  1  reset, **synchronous, active-high**.
- `req0_dv`  in  1  requester 0 data valid.
- `req0_DATA`  in  DATA_WIDTH  requester 0 data.
- `req0_rdy`  out  1  requester 0 holding register can accept this cycle.
- `req1_dv`  in  1  requester 1 data valid.
- `req1_DATA`  in  DATA_WIDTH  requester 1 data.
- `req1_rdy`  out  1  requester 1 holding register can accept this cycle.
- `fifo_wr_dv`  out  1  write strobe to the FIFO.
- `fifo_wr_DATA`  out  DATA_WIDTH+1  `{src_id, payload}`; MSB = 0 for requester 0, 1 for requester 1.
- `fifo_wr_full`  in  1  FIFO full flag.
- `fifo_wr_almost_full`  in  1  FIFO almost-full flag.
- `clr_drops`  in  1  synchronous clear of both drop counters.
- `drop0_cnt`  out  DROP_CNT_WIDTH  requester 0 dropped words.
- `drop1_cnt`  out  DROP_CNT_WIDTH  requester 1 dropped words.

## Operation
State:
- Holding registers `hold0` and `hold1`, each with a valid bit `hN_v`.
- `last_grant`, 1 bit.
- Two drop counters.

Eligibility (combinational):
- `e0 = h0_v`.
- `e1 = h1_v & ~(LOCK_LOW_PRIO & fifo_wr_almost_full)`.

Grant (combinational, never granted when `fifo_wr_full=1` or `rst=1`):
- Only `e0` set: grant 0. Only `e1` set: grant 1.
- Both set: grant the requester that is not `last_grant`.
- `fifo_wr_dv = grant0 | grant1`.
- `fifo_wr_DATA` is the granted hold register with the MSB tag; it is `{1'b0, hold0}` when nothing is granted.

Ready:
- `reqN_rdy = ~hN_v | grantN`, combinational.

At each posedge:
- A granted entry clears `hN_v`, and `last_grant` takes the granted index.
- If `reqN_dv & reqN_rdy`: `holdN <= reqN_DATA`, `hN_v <= 1`. A capture in the same cycle as a grant of that register refills it, so `hN_v` stays 1.
- If `reqN_dv & ~reqN_rdy`: the word is dropped. `dropN_cnt` increments and saturates at all-ones; the hold register is unchanged.
- If `clr_drops`: both counters go to 0. Clear has priority over a same-cycle drop, so the result is 0.

Write ordering: the block never presents a write while `fifo_wr_full=1`, so the FIFO never silently discards a granted word.

Reset (`rst=1` at posedge):
- `h0_v = h1_v = 0`.
- `last_grant = 1`, so requester 0 wins the first tie.
- Both counters = 0.
- While `rst=1`: `fifo_wr_dv = 0` and `req0_rdy = req1_rdy = 0`. `reqN_dv` inputs are ignored and not counted as drops.
- Reset mid-operation discards held words without writing them.

## Timing
- Capture latency: `reqN_dv` sampled at edge t; the word is in `holdN` after t and is presented on `fifo_wr_dv` in cycle t+1 if granted.
- Minimum entry-to-FIFO latency is 1 clock; the FIFO stores the word at edge t+1.
- Sustained throughput: one FIFO write per clock.
  - With one active requester, that requester gets 1 word/clock.
  - With both saturating and the FIFO not almost full, each gets 1 word per 2 clocks, strictly alternating.
- Blocking: `fifo_wr_full`, or `fifo_wr_almost_full` for requester 1, blocks grants in the same cycle. A blocked requester drops on its next `dv` unless it honors `reqN_rdy`.
- `fifo_wr_dv` and `reqN_rdy` are combinational from registers plus the FIFO flags. There is no combinational path from `reqN_dv` to `fifo_wr_dv`.

## Test plan
- **Reset:** drive `rst=1` with both `dv=1` for 3 clocks → `fifo_wr_dv=0` and both `rdy=0` throughout; after release, counters=0, both `rdy=1`.
- **Single source streaming:** `req0` sends 0x11, 0x22, 0x33 on consecutive clocks with the FIFO empty → `fifo_wr_DATA` = 0x011, 0x022, 0x033 on the next three cycles; `drop0_cnt=0`.
- **Contention:** both requesters stream every cycle (req0 0xA0+i, req1 0xB0+i) → writes alternate 0x0A0, 0x1B0, 0x0A1, 0x1B1…; the first grant goes to req0.
- **Almost-full throttle:** hold `fifo_wr_almost_full=1` with both holds valid → only tag-0 writes appear. One more `req1_dv` while `req1_rdy=0` → `drop1_cnt=1`. Deassert almost-full → held req1 word written next cycle.
- **Full stall and saturation:** hold `fifo_wr_full=1` and pulse `req0_dv` 300 times → no writes; `drop0_cnt` = 255 (saturated). Then pulse `clr_drops` in the same cycle as a drop → `drop0_cnt=0`.
- **Grant plus refill:** `req0_dv` in the same cycle `hold0` is granted → `req0_rdy=1`, no drop, and the new word is written in the following cycle.
